// File: rtl/sram_access_arbiter.sv
// Arbiter for the shared 16-bit SRAM between the video scan-out reader and the draw engine.
// Video has priority, and a starvation limit bounds how long the draw engine can wait.
module sram_access_arbiter #(
    parameter int unsigned AW           = 20,
    parameter int unsigned DW           = 16,
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned TURNAROUND   = 1
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iVID_REQ,
    input  logic [AW-1:0] iVID_ADDR,
    output logic [DW-1:0] oVID_DATA,
    output logic          oVID_VALID,
    output logic          oVID_MISS,
    input  logic          iDRW_REQ,
    input  logic          iDRW_WE,
    input  logic [AW-1:0] iDRW_ADDR,
    input  logic [DW-1:0] iDRW_WDATA,
    output logic          oDRW_ACK,
    output logic [DW-1:0] oDRW_RDATA,
    output logic          oDRW_RVALID,
    output logic [AW-1:0] oSRAM_ADDR,
    output logic [DW-1:0] oSRAM_DQ_OUT,
    output logic          oSRAM_DQ_OE,
    input  logic [DW-1:0] iSRAM_DQ_IN,
    output logic          oSRAM_WE_N,
    output logic          oSRAM_OE_N
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
    localparam logic [1:0] TA    = 2'(TURNAROUND);

    typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;
    typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_DRW} tag_t;

    state_t     state, state_nxt;
    logic [1:0] turn_cnt, turn_cnt_nxt;
    logic [7:0] starve, starve_nxt;
    tag_t       tag1, tag1_nxt;
    logic       miss1, miss1_nxt;
    logic       grant_vid, grant_drw;

    // TURN is held exactly while the turnaround counter is nonzero.
    always_comb begin
        grant_vid    = 1'b0;
        grant_drw    = 1'b0;
        state_nxt    = state;
        turn_cnt_nxt = turn_cnt;
        starve_nxt   = starve;
        tag1_nxt     = TAG_NONE;
        miss1_nxt    = 1'b0;

        if (!iRST && state != TURN) begin
            if (iDRW_REQ && (!iVID_REQ || starve == LIMIT))
                grant_drw = 1'b1;
            else if (iVID_REQ)
                grant_vid = 1'b1;
        end

        if (state == TURN) begin
            turn_cnt_nxt = turn_cnt - 2'd1;
            state_nxt    = (turn_cnt == 2'd1) ? IDLE : TURN;
        end else if (grant_drw && iDRW_WE && TA != 2'd0) begin
            turn_cnt_nxt = TA;
            state_nxt    = TURN;
        end else if (grant_vid || grant_drw) begin
            state_nxt = ACCESS;
        end else begin
            state_nxt = IDLE;
        end

        if (grant_drw || !iDRW_REQ)
            starve_nxt = '0;
        else if (grant_vid && starve != LIMIT)
            starve_nxt = starve + 8'd1;

        if (grant_vid)
            tag1_nxt = TAG_VID;
        else if (grant_drw && !iDRW_WE)
            tag1_nxt = TAG_DRW;

        miss1_nxt = iVID_REQ && !grant_vid;
    end

    assign oDRW_ACK = grant_drw;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state    <= IDLE;
            turn_cnt <= '0;
            starve   <= '0;
            tag1     <= TAG_NONE;
            miss1    <= 1'b0;
        end else begin
            state    <= state_nxt;
            turn_cnt <= turn_cnt_nxt;
            starve   <= starve_nxt;
            tag1     <= tag1_nxt;
            miss1    <= miss1_nxt;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oSRAM_ADDR   <= '0;
            oSRAM_DQ_OUT <= '0;
            oSRAM_DQ_OE  <= 1'b0;
            oSRAM_WE_N   <= 1'b1;
            oSRAM_OE_N   <= 1'b1;
        end else begin
            oSRAM_DQ_OE <= 1'b0;
            oSRAM_WE_N  <= 1'b1;
            oSRAM_OE_N  <= 1'b1;
            if (grant_vid) begin
                oSRAM_ADDR <= iVID_ADDR;
                oSRAM_OE_N <= 1'b0;
            end else if (grant_drw) begin
                oSRAM_ADDR <= iDRW_ADDR;
                if (iDRW_WE) begin
                    oSRAM_DQ_OUT <= iDRW_WDATA;
                    oSRAM_DQ_OE  <= 1'b1;
                    oSRAM_WE_N   <= 1'b0;
                end else begin
                    oSRAM_OE_N <= 1'b0;
                end
            end
        end
    end

    // Second pipeline stage: pad data is captured at the end of the bus cycle.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oVID_DATA   <= '0;
            oVID_VALID  <= 1'b0;
            oVID_MISS   <= 1'b0;
            oDRW_RDATA  <= '0;
            oDRW_RVALID <= 1'b0;
        end else begin
            oVID_VALID  <= (tag1 == TAG_VID);
            oDRW_RVALID <= (tag1 == TAG_DRW);
            oVID_MISS   <= miss1;
            if (tag1 == TAG_VID)
                oVID_DATA <= iSRAM_DQ_IN;
            if (tag1 == TAG_DRW)
                oDRW_RDATA <= iSRAM_DQ_IN;
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Scoreboard bench for sram_access_arbiter: a cycle-level reference model queues expected
// responses and a negedge monitor compares them with what the DUT presents.
module tb_sram_access_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int SL = 8;
    localparam int TA = 1;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b1;
    logic          iVID_REQ = 1'b1;
    logic [AW-1:0] iVID_ADDR = '0;
    logic [DW-1:0] oVID_DATA;
    logic          oVID_VALID, oVID_MISS;
    logic          iDRW_REQ = 1'b1;
    logic          iDRW_WE = 1'b1;
    logic [AW-1:0] iDRW_ADDR = '0;
    logic [DW-1:0] iDRW_WDATA = '0;
    logic          oDRW_ACK;
    logic [DW-1:0] oDRW_RDATA;
    logic          oDRW_RVALID;
    logic [AW-1:0] oSRAM_ADDR;
    logic [DW-1:0] oSRAM_DQ_OUT;
    logic          oSRAM_DQ_OE;
    logic [DW-1:0] iSRAM_DQ_IN;
    logic          oSRAM_WE_N, oSRAM_OE_N;

    sram_access_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL), .TURNAROUND(TA)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .iVID_REQ(iVID_REQ), .iVID_ADDR(iVID_ADDR), .oVID_DATA(oVID_DATA),
        .oVID_VALID(oVID_VALID), .oVID_MISS(oVID_MISS),
        .iDRW_REQ(iDRW_REQ), .iDRW_WE(iDRW_WE), .iDRW_ADDR(iDRW_ADDR),
        .iDRW_WDATA(iDRW_WDATA), .oDRW_ACK(oDRW_ACK), .oDRW_RDATA(oDRW_RDATA),
        .oDRW_RVALID(oDRW_RVALID), .oSRAM_ADDR(oSRAM_ADDR), .oSRAM_DQ_OUT(oSRAM_DQ_OUT),
        .oSRAM_DQ_OE(oSRAM_DQ_OE), .iSRAM_DQ_IN(iSRAM_DQ_IN),
        .oSRAM_WE_N(oSRAM_WE_N), .oSRAM_OE_N(oSRAM_OE_N)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    // Simple SRAM device: 1K words aliased over the address space.
    logic [15:0] sram [0:1023];
    always @(posedge iCLK) if (oSRAM_WE_N === 1'b0) sram[oSRAM_ADDR[9:0]] <= oSRAM_DQ_OUT;
    assign iSRAM_DQ_IN = (oSRAM_OE_N === 1'b0) ? sram[oSRAM_ADDR[9:0]] : 16'hBEEF;

    typedef struct { int cyc; logic [15:0] d; } ev_t;
    typedef struct { int cyc; logic [AW-1:0] addr; logic [15:0] dout; logic dqoe, we_n, oe_n; } bus_t;
    ev_t  vid_q[$], drw_q[$], miss_q[$], ack_q[$];
    bus_t bus_q[$];

    int checks = 0, failures = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model state.
    logic [15:0]   ref_mem [0:1023];
    int            starve = 0, turn_left = 0;
    logic [AW-1:0] last_addr = '0;
    logic [15:0]   last_dout = '0;
    logic          d_req = 1'b1, d_we = 1'b1;
    logic [AW-1:0] d_addr = '0;
    logic [15:0]   d_wdata = '0;

    task automatic step(input logic rst, input logic vreq, input logic [AW-1:0] vaddr, output logic dgrant);
        int g;
        bus_t b;
        @(posedge iCLK); #1;
        iRST = rst; iVID_REQ = vreq; iVID_ADDR = vaddr;
        iDRW_REQ = d_req; iDRW_WE = d_we; iDRW_ADDR = d_addr; iDRW_WDATA = d_wdata;
        g = 0;
        if (!rst && turn_left == 0) begin
            if (d_req && (!vreq || starve == SL)) g = 2;
            else if (vreq) g = 1;
        end
        ack_q.push_back('{cyc, 16'(g == 2)});
        if (rst) begin
            starve = 0; turn_left = 0; last_addr = '0; last_dout = '0;
            while (vid_q.size() > 0 && vid_q[$].cyc > cyc) void'(vid_q.pop_back());
            while (drw_q.size() > 0 && drw_q[$].cyc > cyc) void'(drw_q.pop_back());
            while (miss_q.size() > 0 && miss_q[$].cyc > cyc) void'(miss_q.pop_back());
            bus_q.push_back('{cyc + 1, '0, '0, 1'b0, 1'b1, 1'b1});
        end else begin
            b = '{cyc + 1, last_addr, last_dout, 1'b0, 1'b1, 1'b1};
            if (g == 1) begin
                b.addr = vaddr; b.oe_n = 1'b0;
                vid_q.push_back('{cyc + 2, ref_mem[vaddr[9:0]]});
            end else if (g == 2) begin
                b.addr = d_addr;
                if (d_we) begin
                    b.dout = d_wdata; b.dqoe = 1'b1; b.we_n = 1'b0;
                    ref_mem[d_addr[9:0]] = d_wdata;
                end else begin
                    b.oe_n = 1'b0;
                    drw_q.push_back('{cyc + 2, ref_mem[d_addr[9:0]]});
                end
            end
            last_addr = b.addr; last_dout = b.dout;
            bus_q.push_back(b);
            if (vreq && g != 1) miss_q.push_back('{cyc + 2, 16'd0});
            if (g == 2 && d_we) turn_left = TA;
            else if (turn_left > 0) turn_left--;
            if (g == 2 || !d_req) starve = 0;
            else if (g == 1 && starve < SL) starve++;
        end
        dgrant = (g == 2);
    endtask

    // Monitor: pops the scoreboard whenever an expected response falls due.
    logic [15:0] vid_hold = '0, drw_hold = '0;
    always @(negedge iCLK) begin
        ev_t  e;
        bus_t b;
        logic exp_v;
        if (cyc >= 1) begin
            if (ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
                e = ack_q.pop_front();
                chk("drw_ack", oDRW_ACK, e.d[0]);
            end
            if (bus_q.size() > 0 && bus_q[0].cyc == cyc) begin
                b = bus_q.pop_front();
                chk("sram_bus", {oSRAM_ADDR, oSRAM_DQ_OUT, oSRAM_DQ_OE, oSRAM_WE_N, oSRAM_OE_N},
                    {b.addr, b.dout, b.dqoe, b.we_n, b.oe_n});
            end
            exp_v = vid_q.size() > 0 && vid_q[0].cyc == cyc;
            chk("vid_valid", oVID_VALID, exp_v);
            if (exp_v) begin e = vid_q.pop_front(); vid_hold = e.d; end
            chk("vid_data", oVID_DATA, vid_hold);
            exp_v = drw_q.size() > 0 && drw_q[0].cyc == cyc;
            chk("drw_rvalid", oDRW_RVALID, exp_v);
            if (exp_v) begin e = drw_q.pop_front(); drw_hold = e.d; end
            chk("drw_rdata", oDRW_RDATA, drw_hold);
            exp_v = miss_q.size() > 0 && miss_q[0].cyc == cyc;
            chk("vid_miss", oVID_MISS, exp_v);
            if (exp_v) void'(miss_q.pop_front());
            if (iRST) begin vid_hold = '0; drw_hold = '0; end
        end
    end

    task automatic hold_draw(input logic vreq_on, input int vbase, input string nm);
        logic g;
        int   n;
        g = 1'b0; n = 0;
        while (!g && n < 40) begin
            step(1'b0, vreq_on, AW'(vbase + n), g);
            n++;
        end
        d_req = 1'b0;
        chk({nm, "_granted_in_bound"}, 64'(g), 64'd1);
    endtask

    initial begin
        logic g;
        for (int i = 0; i < 1024; i++) begin
            sram[i] = 16'(i);
            ref_mem[i] = 16'(i);
        end
        bus_q.push_back('{1, '0, '0, 1'b0, 1'b1, 1'b1});

        // Reset with every request asserted.
        d_req = 1'b1; d_we = 1'b1; d_addr = 20'h00055; d_wdata = 16'h1234;
        repeat (3) step(1'b1, 1'b1, 20'h00077, g);
        step(1'b0, 1'b0, '0, g);
        d_req = 1'b0;

        // Video only, addresses 0..9.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, AW'(i), g);

        // Starvation: draw read held against continuous video.
        d_req = 1'b1; d_we = 1'b0; d_addr = 20'h12345;
        hold_draw(1'b1, 100, "starve");
        repeat (4) step(1'b0, 1'b1, 20'h00200, g);
        repeat (2) step(1'b0, 1'b0, '0, g);

        // Write followed by continuous video: turnaround idle cycle.
        d_req = 1'b1; d_we = 1'b1; d_addr = {10'd80, 10'd200}; d_wdata = 16'hFFFF;
        hold_draw(1'b0, 0, "write");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, {10'd80, 10'd200}, g);

        // Simultaneous requests with starve=0, then read back the written word.
        step(1'b0, 1'b0, '0, g);
        d_req = 1'b1; d_we = 1'b0; d_addr = {10'd80, 10'd200};
        hold_draw(1'b1, 300, "simul");
        repeat (3) step(1'b0, 1'b0, '0, g);

        // Reset during the write's bus cycle, then reset during a read in flight.
        d_req = 1'b1; d_we = 1'b1; d_addr = 20'h003A0; d_wdata = 16'hA5A5;
        step(1'b0, 1'b0, '0, g);
        d_req = 1'b0;
        step(1'b1, 1'b0, '0, g);
        step(1'b0, 1'b0, '0, g);
        d_req = 1'b1; d_we = 1'b0; d_addr = 20'h003A0;
        step(1'b0, 1'b0, '0, g);
        d_req = 1'b0;
        step(1'b1, 1'b1, 20'h00011, g);
        repeat (3) step(1'b0, 1'b0, '0, g);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (!d_req && $urandom_range(0, 3) == 0) begin
                d_req = 1'b1;
                d_we = 1'($urandom_range(0, 1));
                d_addr = AW'($urandom);
                d_wdata = 16'($urandom);
            end
            step(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 9) < 7), AW'($urandom), g);
            if (g) d_req = 1'b0;
        end

        d_req = 1'b0;
        repeat (5) step(1'b0, 1'b0, '0, g);
        @(negedge iCLK); #1;
        chk("scoreboard_drained", 64'(vid_q.size() + drw_q.size() + miss_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
